// File: rtl/thermal_pkg.sv
// Shared definitions for the thermostat plant and controller: mode encoding
// and Q8.8 temperature format constants.
package thermal_pkg;

    // Plant / controller mode; 2'b11 is unused and treated as illegal.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEATING = 2'b01,
        COOLING = 2'b10
    } mode_t;

    // Signed Q8.8 temperature format.
    localparam int unsigned TEMP_W    = 16;
    localparam int unsigned TEMP_FRAC = 8;

    // Common temperature constants in Q8.8.
    localparam logic [TEMP_W-1:0] TEMP_0_0  = 16'h0000;
    localparam logic [TEMP_W-1:0] TEMP_20_0 = 16'h1400;
    localparam logic [TEMP_W-1:0] TEMP_40_0 = 16'h2800;

endpackage

// File: rtl/thermal_step.sv
// Combinational temperature step: ambient drift (bounded so it never
// overshoots ambient), conditioning rate for the given mode, then clamp.
// All arithmetic is signed at W+2 bits so no intermediate can wrap.
module thermal_step
    import thermal_pkg::*;
#(
    parameter int unsigned  W         = TEMP_W,
    parameter logic [W-1:0] T_MIN     = W'(TEMP_0_0),
    parameter logic [W-1:0] T_MAX     = W'(TEMP_40_0),
    parameter logic [W-1:0] AMB_RATE  = W'(16'h0010),
    parameter logic [W-1:0] HEAT_RATE = W'(16'h0080),
    parameter logic [W-1:0] COOL_RATE = W'(16'h0080)
) (
    input  logic [W-1:0] temp,
    input  logic [W-1:0] ambient,
    input  mode_t        mode,
    output logic [W-1:0] next_temp
);

    localparam int unsigned XW = W + 2;

    function automatic logic signed [XW-1:0] sx(input logic [W-1:0] v);
        return signed'({{2{v[W-1]}}, v});
    endfunction

    logic signed [XW-1:0] t_x;
    logic signed [XW-1:0] a_x;
    logic signed [XW-1:0] d;
    logic signed [XW-1:0] neg_d;
    logic signed [XW-1:0] amb_x;
    logic signed [XW-1:0] drift;
    logic signed [XW-1:0] cond;
    logic signed [XW-1:0] sum;
    logic signed [XW-1:0] lo_x;
    logic signed [XW-1:0] hi_x;

    // Drift toward ambient, conditioning contribution and saturation.
    always_comb begin
        t_x   = sx(temp);
        a_x   = sx(ambient);
        amb_x = sx(AMB_RATE);
        lo_x  = sx(T_MIN);
        hi_x  = sx(T_MAX);
        d     = a_x - t_x;
        neg_d = -d;

        drift = '0;
        if (!d[XW-1] && (d != '0)) begin
            drift = (d > amb_x) ? amb_x : d;
        end else if (d[XW-1]) begin
            drift = (neg_d > amb_x) ? -amb_x : d;
        end

        cond = '0;
        case (mode)
            HEATING: cond =  sx(HEAT_RATE);
            COOLING: cond = -sx(COOL_RATE);
            default: cond = '0;
        endcase

        sum = t_x + drift + cond;

        if (sum < lo_x) begin
            next_temp = T_MIN;
        end else if (sum > hi_x) begin
            next_temp = T_MAX;
        end else begin
            next_temp = sum[W-1:0];
        end
    end

endmodule

// File: rtl/thermal_plant.sv
// Room thermal model: samples heater/cooler commands and ambient once per
// UPDATE_DIV cycles, tracks plant mode and a sticky conflict fault, and
// updates the Q8.8 room temperature with a one-cycle valid pulse.
module thermal_plant
    import thermal_pkg::*;
#(
    parameter int unsigned  W          = TEMP_W,
    parameter int unsigned  UPDATE_DIV = 10,
    parameter logic [W-1:0] T_INIT     = W'(TEMP_20_0),
    parameter logic [W-1:0] T_MIN      = W'(TEMP_0_0),
    parameter logic [W-1:0] T_MAX      = W'(TEMP_40_0),
    parameter logic [W-1:0] AMB_RATE   = W'(16'h0010),
    parameter logic [W-1:0] HEAT_RATE  = W'(16'h0080),
    parameter logic [W-1:0] COOL_RATE  = W'(16'h0080)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         heat_on,
    input  logic         cool_on,
    input  logic [W-1:0] ambient,
    output logic [W-1:0] temp,
    output logic         temp_valid,
    output logic [1:0]   mode,
    output logic         fault
);

    localparam int unsigned        CNT_W    = $clog2(UPDATE_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(UPDATE_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             conflict;
    mode_t            mode_q;
    mode_t            mode_next;
    logic [W-1:0]     temp_next;

    assign tick = (cnt == CNT_LAST);
    assign mode = mode_q;

    // Decode the commands into the mode the plant takes at the next tick.
    always_comb begin
        mode_next = IDLE;
        conflict  = 1'b0;
        case ({heat_on, cool_on})
            2'b10:   mode_next = HEATING;
            2'b01:   mode_next = COOLING;
            2'b11:   conflict  = 1'b1;
            default: mode_next = IDLE;
        endcase
    end

    thermal_step #(
        .W         (W),
        .T_MIN     (T_MIN),
        .T_MAX     (T_MAX),
        .AMB_RATE  (AMB_RATE),
        .HEAT_RATE (HEAT_RATE),
        .COOL_RATE (COOL_RATE)
    ) u_step (
        .temp      (temp),
        .ambient   (ambient),
        .mode      (mode_next),
        .next_temp (temp_next)
    );

    // Sample counter, mode FSM, sticky fault and temperature register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt        <= '0;
            temp       <= T_INIT;
            temp_valid <= 1'b0;
            mode_q     <= IDLE;
            fault      <= 1'b0;
        end else begin
            temp_valid <= tick;
            if (tick) begin
                cnt    <= '0;
                mode_q <= mode_next;
                temp   <= temp_next;
                if (conflict) begin
                    fault <= 1'b1;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (!(mode_q inside {IDLE, HEATING, COOLING})) begin
                    mode_q <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_thermal_plant.sv
// Self-checking bench for thermal_plant with UPDATE_DIV=4: directed vector
// table, hand-written multi-cycle sequences, and randomized stimulus compared
// every cycle against an arithmetic reference model.
module tb_thermal_plant;

    localparam int DIV   = 4;
    localparam int AMB_R = 16'h0010;
    localparam int HEAT  = 16'h0080;
    localparam int COOL  = 16'h0080;
    localparam int TMIN  = 16'h0000;
    localparam int TMAX  = 16'h2800;
    localparam int TINIT = 16'h1400;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        heat_on = 1'b0;
    logic        cool_on = 1'b0;
    logic [15:0] ambient = 16'h1400;
    logic [15:0] temp;
    logic        temp_valid;
    logic [1:0]  mode;
    logic        fault;

    thermal_plant #(
        .W          (16),
        .UPDATE_DIV (DIV)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .heat_on    (heat_on),
        .cool_on    (cool_on),
        .ambient    (ambient),
        .temp       (temp),
        .temp_valid (temp_valid),
        .mode       (mode),
        .fault      (fault)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: temperature as plain integer, mode 0/1/2,
    // and the number of cycles elapsed in the current sample period.
    int m_temp  = TINIT;
    int m_mode  = 0;
    int m_fault = 0;
    int m_valid = 0;
    int m_phase = 0;

    typedef struct {
        logic        heat;
        logic        cool;
        logic [15:0] amb;
        logic [15:0] exp_temp;
        logic [1:0]  exp_mode;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_edge();
        int amb;
        int d;
        int drift;
        int cond;
        int nxt;
        if (reset) begin
            m_temp  = TINIT;
            m_mode  = 0;
            m_fault = 0;
            m_valid = 0;
            m_phase = 0;
        end else begin
            m_valid = (m_phase == DIV - 1) ? 1 : 0;
            if (m_valid == 1) begin
                amb = int'($signed(ambient));
                if (heat_on && !cool_on)      m_mode = 1;
                else if (!heat_on && cool_on) m_mode = 2;
                else                          m_mode = 0;
                if (heat_on && cool_on) m_fault = 1;
                d = amb - m_temp;
                if (d > 0)      drift = (d < AMB_R) ? d : AMB_R;
                else if (d < 0) drift = (-d < AMB_R) ? d : -AMB_R;
                else            drift = 0;
                cond = (m_mode == 1) ? HEAT : ((m_mode == 2) ? -COOL : 0);
                nxt = m_temp + drift + cond;
                if (nxt < TMIN) nxt = TMIN;
                if (nxt > TMAX) nxt = TMAX;
                m_temp = nxt;
            end
            m_phase = (m_phase + 1) % DIV;
        end
    endtask

    task automatic step_cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("model_temp",  int'(temp),       m_temp);
        check("model_mode",  int'(mode),       m_mode);
        check("model_fault", int'(fault),      m_fault);
        check("model_valid", int'(temp_valid), m_valid);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step_cycle();
        step_cycle();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h1400, 16'h1400, 2'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h1400, 16'h1480, 2'd1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h1400, 16'h14F0, 2'd1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h1400, 16'h1460, 2'd2, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 16'h1400, 16'h1450, 2'd0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 16'h1400, 16'h1440, 2'd0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h1445, 16'h1445, 2'd0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h1445, 16'h1445, 2'd0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 16'h0000, 16'h13B5, 2'd2, 1'b1};

        // Reset state
        do_reset();
        check("reset_temp",  int'(temp),       TINIT);
        check("reset_mode",  int'(mode),       0);
        check("reset_fault", int'(fault),      0);
        check("reset_valid", int'(temp_valid), 0);

        // Directed table, one sample period per row
        for (int i = 0; i < 9; i++) begin
            heat_on = vecs[i].heat;
            cool_on = vecs[i].cool;
            ambient = vecs[i].amb;
            repeat (DIV) step_cycle();
            check($sformatf("vec%0d_temp", i),  int'(temp),       int'(vecs[i].exp_temp));
            check($sformatf("vec%0d_mode", i),  int'(mode),       int'(vecs[i].exp_mode));
            check($sformatf("vec%0d_fault", i), int'(fault),      int'(vecs[i].exp_fault));
            check($sformatf("vec%0d_valid", i), int'(temp_valid), 1);
        end

        // No overshoot from reset
        do_reset();
        heat_on = 1'b0;
        cool_on = 1'b0;
        ambient = 16'h1408;
        repeat (DIV) step_cycle();
        check("overshoot_t1", int'(temp), 16'h1408);
        repeat (DIV) step_cycle();
        check("overshoot_t2", int'(temp), 16'h1408);

        // Saturation at the upper clamp
        do_reset();
        heat_on = 1'b1;
        ambient = 16'h2800;
        for (int i = 1; i <= 40; i++) begin
            int exp_t;
            repeat (DIV) step_cycle();
            exp_t = TINIT + 16'h90 * i;
            if (exp_t > TMAX) exp_t = TMAX;
            check($sformatf("sat_tick%0d", i), int'(temp), exp_t);
        end
        check("sat_mode",  int'(mode),  1);
        check("sat_fault", int'(fault), 0);

        // Reset mid-period after heating to 0x14F0
        do_reset();
        heat_on = 1'b1;
        ambient = 16'h1400;
        repeat (2 * DIV) step_cycle();
        check("midrst_pre_temp", int'(temp), 16'h14F0);
        repeat (2) step_cycle();
        reset = 1'b1;
        step_cycle();
        check("midrst_temp",  int'(temp),       TINIT);
        check("midrst_mode",  int'(mode),       0);
        check("midrst_valid", int'(temp_valid), 0);
        reset = 1'b0;
        for (int i = 1; i <= DIV; i++) begin
            step_cycle();
            check($sformatf("midrst_valid_c%0d", i), int'(temp_valid), (i == DIV) ? 1 : 0);
        end

        // Reset on the tick cycle suppresses the update
        do_reset();
        repeat (DIV - 1) step_cycle();
        reset = 1'b1;
        step_cycle();
        check("tickrst_temp",  int'(temp),       TINIT);
        check("tickrst_valid", int'(temp_valid), 0);
        reset = 1'b0;
        repeat (DIV) step_cycle();
        check("tickrst_after", int'(temp), 16'h1480);

        // Randomized stimulus held for random spans, occasional resets
        do_reset();
        for (int blk = 0; blk < 120; blk++) begin
            int span;
            heat_on = 1'($urandom_range(0, 1));
            cool_on = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       ambient = 16'h8000;
                1:       ambient = 16'h7FFF;
                2:       ambient = 16'h2800;
                3:       ambient = 16'h0000;
                default: ambient = 16'($urandom_range(0, 16'h2C00));
            endcase
            reset = ($urandom_range(0, 29) == 0);
            span = $urandom_range(1, 14);
            for (int c = 0; c < span; c++) begin
                step_cycle();
                reset = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
